// File: rtl/jk_sync_counter_pkg.sv
// ---------------------------------------------------------------------------
// jk_sync_counter_pkg : shared mode encodings and default width
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jk_sync_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_COUNT = 2'd2
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/jk_sync_counter_jk_ff_sync.sv
// ---------------------------------------------------------------------------
// jk_ff_sync : single JK flip-flop with synchronous active-low reset
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_ff_sync (
  input  logic clk,
  input  logic reset,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({J, K})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

`default_nettype wire

// File: rtl/jk_sync_counter.sv
// ---------------------------------------------------------------------------
// jk_sync_counter : up/down counter with load, saturate/wrap, built on JK cells
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_sync_counter
  import jk_sync_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_p
);

  localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e            mode;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;
  logic             wrap_p_d;
  logic             wrap_p_q;

  assign tc = (up && (q == C_MAX)) || (!up && (q == C_ZERO));

  always_comb begin
    mode = MODE_HOLD;
    if (load) begin
      mode = MODE_LOAD;
    end else if (en) begin
      mode = MODE_COUNT;
    end
  end

  always_comb begin
    nxt      = q;
    wrap_p_d = 1'b0;
    case (mode)
      MODE_LOAD: nxt = load_val;
      MODE_COUNT: begin
        if (!tc) begin
          nxt = up ? (q + C_ONE) : (q - C_ONE);
        end else if (!sat) begin
          // At the end value, wrap to the opposite end and flag it
          nxt      = up ? C_ZERO : C_MAX;
          wrap_p_d = 1'b1;
        end
      end
      default: nxt = q;
    endcase
  end

  // Excitation only sets or clears, so the toggle combination never arises
  assign jk_j = nxt & ~q;
  assign jk_k = ~nxt & q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_ff_sync u_cell (
        .clk   (clk),
        .reset (reset),
        .J     (jk_j[i]),
        .K     (jk_k[i]),
        .Q     (q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_p_q <= 1'b0;
    end else begin
      wrap_p_q <= wrap_p_d;
    end
  end

  assign wrap_p = wrap_p_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_sync_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_sync_counter : scoreboard bench with directed plan and random traffic
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jk_sync_counter;

  localparam int W   = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int q;
    bit wrap;
    bit tc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         sat = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap_p;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   m_q = 0;

  jk_sync_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap_p   (wrap_p)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue what the counter must show after the edge
  task automatic step(input bit r, input bit ld, input int lv, input bit e,
                      input bit u, input bit s);
    exp_t x;
    @(negedge clk);
    reset = r; load = ld; load_val = lv[W-1:0]; en = e; up = u; sat = s;
    x.wrap = 1'b0;
    if (!r) begin
      m_q = 0;
    end else if (ld) begin
      m_q = lv % (MAXV + 1);
    end else if (e) begin
      if (u && m_q == MAXV) begin
        if (!s) begin m_q = 0; x.wrap = 1'b1; end
      end else if (!u && m_q == 0) begin
        if (!s) begin m_q = MAXV; x.wrap = 1'b1; end
      end else begin
        m_q = u ? m_q + 1 : m_q - 1;
      end
    end
    x.q  = m_q;
    x.tc = u ? (m_q == MAXV) : (m_q == 0);
    sb.push_back(x);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (q !== e.q[W-1:0]) begin
          bad++;
          $display("FAIL q: got %0d expected %0d at %0t", q, e.q, $time);
        end
        total++;
        if (wrap_p !== e.wrap) begin
          bad++;
          $display("FAIL wrap_p: got %b expected %b (q=%0d) at %0t", wrap_p, e.wrap, e.q, $time);
        end
        total++;
        if (tc !== e.tc) begin
          bad++;
          $display("FAIL tc: got %b expected %b (q=%0d up=%b) at %0t", tc, e.tc, e.q, up, $time);
        end
      end
    end
  end

  initial begin
    // Reset overrides load and en
    step(0, 1, 9, 1, 1, 0);
    step(0, 1, 9, 1, 1, 0);
    repeat (3) step(1, 0, 0, 1, 1, 0);
    // Wrap upward
    step(1, 1, 14, 0, 1, 0);
    repeat (3) step(1, 0, 0, 1, 1, 0);
    // Wrap downward, then reverse direction at the end value
    step(1, 1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    // Saturate at the top, then step back down
    step(1, 1, 13, 0, 1, 1);
    repeat (5) step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 0, 1);
    // Load beats counting at terminal count, then hold
    step(1, 1, 15, 0, 1, 0);
    step(1, 1, 5, 1, 1, 0);
    repeat (3) step(1, 0, 0, 0, 1, 0);
    // Reset mid-count, in the same cycle as a load
    step(1, 1, 6, 0, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 1, 11, 1, 1, 0);
    repeat (2) step(1, 0, 0, 1, 1, 0);
    // Reset landing right after a wrap clears the pending pulse
    step(1, 1, 15, 0, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, MAXV)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0) ? up : ~up, ($urandom_range(0, 2) == 0));
    end
    @(negedge clk);
    reset = 1'b1; load = 1'b0; en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
